// File: rtl/spi_tx_arbiter_if.sv
// Requester-side and serializer-side signal bundle of the SPI TX arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface spi_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         ser_data;
  logic                      ser_start;
  logic                      ser_done;
  logic [GW-1:0]             grant_id;
  logic                      busy;
  logic                      err_timeout;

  modport master (
    input  req, req_data, req_last, ser_done,
    output ack, ser_data, ser_start, grant_id, busy, err_timeout
  );

  modport slave (
    output req, req_data, req_last, ser_done,
    input  ack, ser_data, ser_start, grant_id, busy, err_timeout
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter feeding one byte at a time to a shared SPI serializer, with frame lock.
// Optional WAIT watchdog enabled by defining ARB_TIMEOUT_EN.
module spi_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  spi_tx_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_q, last_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               start_q, start_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               lock_q, lock_d;

  logic               win_vld;
  logic [GW-1:0]      win_id;
  logic [GW:0]        idx;
  logic               done_v;
  logic               load;
  logic [GW-1:0]      load_id;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          err_q, err_d;
`endif

  // Descending scan so the nearest requester after last_q is the one left standing.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = {1'b0, last_q} + (GW+1)'(i);
      if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
      if (bus.req[idx[GW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    data_d  = data_q;
    start_d = 1'b0;
    ack_d   = '0;
    lock_d  = lock_q;
    load    = 1'b0;
    load_id = grant_q;
    // The serializer cannot finish in the cycle it is started.
    done_v  = bus.ser_done && !start_q;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          load    = 1'b1;
          load_id = win_id;
        end
      end
      WAIT: begin
        if (done_v) begin
          if (lock_q && bus.req[grant_q]) begin
            load = 1'b1;
          end else begin
            last_d  = grant_q;
            lock_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ARB_TIMEOUT_EN
    cnt_inc = cnt_q + CW'(1);
    cnt_d   = (state_q == WAIT) ? cnt_inc : cnt_q;
    err_d   = err_q;
    if (state_q == WAIT && !done_v && cnt_inc == CW'(TIMEOUT_CYC)) begin
      err_d   = 1'b1;
      lock_d  = 1'b0;
      last_d  = grant_q;
      state_d = IDLE;
    end
    if (load) cnt_d = '0;
`endif

    if (load) begin
      state_d = WAIT;
      grant_d = load_id;
      data_d  = bus.req_data[load_id*DATA_W +: DATA_W];
      start_d = 1'b1;
      ack_d   = NUM_REQ'(1) << load_id;
      lock_d  = ~bus.req_last[load_id];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      data_q  <= '0;
      start_q <= 1'b0;
      ack_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      lock_q  <= lock_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.ack       = ack_q;
  assign bus.ser_data  = data_q;
  assign bus.ser_start = start_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q == WAIT);

endmodule
